// File: rtl/mem_port_arbiter.sv
// Arbiter for the single unified instruction/data memory port.
// The MEM-stage data request has fixed priority over the IF-stage fetch
// because MEM holds the older instruction. Every access walks
// IDLE -> DATA/FETCH -> DONE -> IDLE, so the same held request is never
// issued twice. The owner's address, write enable and write data are
// latched at grant, which keeps the memory-side signals stable for the
// whole access.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DATA  = 2'd1,
      S_FETCH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              owner_data_q, owner_data_d;  // 1 = data stage owns the access
   logic              drop_q, drop_d;              // fetch was redirected; discard its data
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   // State and datapath registers; reset abandons any in-flight access.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         owner_data_q <= 1'b0;
         drop_q       <= 1'b0;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         owner_data_q <= owner_data_d;
         drop_q       <= drop_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   // Next-state logic: grant in IDLE, wait for mem_ready, one DONE cycle.
   always_comb begin
      state_d      = state_q;
      owner_data_d = owner_data_q;
      drop_d       = drop_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (d_req) begin
               state_d      = S_DATA;
               owner_data_d = 1'b1;
               addr_d       = d_addr;
               we_d         = d_we;
               wdata_d      = d_wdata;
            end else if (if_req && !if_flush) begin
               state_d      = S_FETCH;
               owner_data_d = 1'b0;
               addr_d       = if_addr;
               we_d         = 1'b0;
            end
         end
         S_DATA: begin
            if (mem_ready) begin
               d_rdata_d = mem_rdata;
               state_d   = S_DONE;
            end
         end
         S_FETCH: begin
            // The memory access is not aborted on redirect; only its result is.
            if (if_flush) begin
               drop_d = 1'b1;
            end
            if (mem_ready) begin
               if_rdata_d = mem_rdata;
               state_d    = S_DONE;
            end
         end
         S_DONE: begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Memory-side, completion and stall outputs.
   always_comb begin
      mem_req   = (state_q == S_DATA) || (state_q == S_FETCH);
      mem_we    = (state_q == S_DATA) && we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      d_valid   = (state_q == S_DONE) && owner_data_q;
      if_valid  = (state_q == S_DONE) && !owner_data_q && !drop_q && !if_flush;
      if_rdata  = if_rdata_q;
      d_rdata   = d_rdata_q;
      stall_mem = d_req && !d_valid;
      stall_if  = (if_req && !if_valid) || stall_mem;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs are driven 1 ns after the
// rising edge and outputs are checked 1 ns after that, mid-cycle.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_flush, d_req, d_we, mem_ready;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic        if_valid, d_valid, mem_req, mem_we, stall_if, stall_mem;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, obs);
      end
   endtask

   // Advance one cycle and land just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after input changes.
   task automatic settle();
      #1;
   endtask

   initial begin
      rst_n = 1'b0; if_req = 0; if_flush = 0; d_req = 0; d_we = 0; mem_ready = 0;
      if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
      tick(); tick();
      rst_n = 1'b1;
      settle();
      check_eq("rst mem_req",   32'(mem_req),   32'd0);
      check_eq("rst mem_we",    32'(mem_we),    32'd0);
      check_eq("rst d_valid",   32'(d_valid),   32'd0);
      check_eq("rst if_valid",  32'(if_valid),  32'd0);
      check_eq("rst mem_addr",  mem_addr,       32'h0);
      check_eq("rst d_rdata",   d_rdata,        32'h0);
      check_eq("rst stall_if",  32'(stall_if),  32'd0);

      // Reset in the middle of a load access with mem_ready high.
      tick();
      d_req = 1; d_we = 0; d_addr = 32'h40;
      settle();
      check_eq("rstacc stall_mem idle", 32'(stall_mem), 32'd1);
      tick();
      check_eq("rstacc mem_req", 32'(mem_req), 32'd1);
      check_eq("rstacc mem_addr", mem_addr, 32'h40);
      rst_n = 0; mem_ready = 1; mem_rdata = 32'h11111111;
      tick();
      rst_n = 1; d_req = 0; mem_ready = 0;
      settle();
      check_eq("rstacc mem_req after", 32'(mem_req), 32'd0);
      check_eq("rstacc d_valid after", 32'(d_valid), 32'd0);
      tick();
      check_eq("rstacc d_valid later", 32'(d_valid), 32'd0);
      check_eq("rstacc mem_req later", 32'(mem_req), 32'd0);
      check_eq("rstacc d_rdata", d_rdata, 32'h0);

      // Single zero-wait load.
      d_req = 1; d_we = 0; d_addr = 32'h100;
      settle();
      check_eq("ld t stall_mem", 32'(stall_mem), 32'd1);
      check_eq("ld t mem_req", 32'(mem_req), 32'd0);
      tick();
      check_eq("ld t+1 mem_req", 32'(mem_req), 32'd1);
      check_eq("ld t+1 mem_addr", mem_addr, 32'h100);
      check_eq("ld t+1 mem_we", 32'(mem_we), 32'd0);
      check_eq("ld t+1 stall_mem", 32'(stall_mem), 32'd1);
      mem_ready = 1; mem_rdata = 32'hDEADBEEF;
      tick();
      mem_ready = 0;
      settle();
      check_eq("ld t+2 d_valid", 32'(d_valid), 32'd1);
      check_eq("ld t+2 d_rdata", d_rdata, 32'hDEADBEEF);
      check_eq("ld t+2 stall_mem", 32'(stall_mem), 32'd0);
      check_eq("ld t+2 mem_req", 32'(mem_req), 32'd0);
      d_req = 0;
      tick();
      check_eq("ld t+3 d_valid", 32'(d_valid), 32'd0);

      // Contention: store wins, then the fetch.
      if_req = 1; if_addr = 32'h8;
      d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h12345678;
      settle();
      check_eq("ct idle stall_if", 32'(stall_if), 32'd1);
      tick();
      check_eq("ct mem_we", 32'(mem_we), 32'd1);
      check_eq("ct mem_addr", mem_addr, 32'h200);
      check_eq("ct mem_wdata", mem_wdata, 32'h12345678);
      tick();
      check_eq("ct wait1 mem_req", 32'(mem_req), 32'd1);
      check_eq("ct wait1 stall_if", 32'(stall_if), 32'd1);
      tick();
      check_eq("ct wait2 mem_addr", mem_addr, 32'h200);
      tick();
      check_eq("ct wait3 stall_if", 32'(stall_if), 32'd1);
      mem_ready = 1; mem_rdata = 32'hAAAA5555;
      tick();
      mem_ready = 0;
      settle();
      check_eq("ct d_valid", 32'(d_valid), 32'd1);
      check_eq("ct if_valid in data done", 32'(if_valid), 32'd0);
      check_eq("ct done stall_if", 32'(stall_if), 32'd1);
      check_eq("ct store d_rdata", d_rdata, 32'hAAAA5555);
      d_req = 0; d_we = 0;
      tick();
      check_eq("ct idle2 mem_req", 32'(mem_req), 32'd0);
      check_eq("ct idle2 stall_if", 32'(stall_if), 32'd1);
      tick();
      check_eq("ct fetch mem_addr", mem_addr, 32'h8);
      check_eq("ct fetch mem_we", 32'(mem_we), 32'd0);
      mem_ready = 1; mem_rdata = 32'h00000013;
      tick();
      mem_ready = 0;
      settle();
      check_eq("ct if_valid", 32'(if_valid), 32'd1);
      check_eq("ct if_rdata", if_rdata, 32'h00000013);
      check_eq("ct stall_if released", 32'(stall_if), 32'd0);
      if_req = 0;
      tick();

      // Flush in IDLE blocks the fetch grant that cycle.
      if_req = 1; if_addr = 32'h30; if_flush = 1;
      tick();
      if_req = 0; if_flush = 0;
      settle();
      check_eq("flidle mem_req", 32'(mem_req), 32'd0);
      tick();

      // Redirect during a fetch: access completes, result dropped.
      if_req = 1; if_addr = 32'h10;
      tick();
      check_eq("rd fetch mem_addr", mem_addr, 32'h10);
      if_flush = 1;
      settle();
      check_eq("rd flush if_valid", 32'(if_valid), 32'd0);
      tick();
      if_flush = 0; if_addr = 32'h50;
      settle();
      check_eq("rd latched mem_addr", mem_addr, 32'h10);
      check_eq("rd still mem_req", 32'(mem_req), 32'd1);
      mem_ready = 1; mem_rdata = 32'h00000BAD;
      tick();
      mem_ready = 0;
      settle();
      check_eq("rd dropped if_valid", 32'(if_valid), 32'd0);
      check_eq("rd done mem_req", 32'(mem_req), 32'd0);
      tick();
      check_eq("rd idle mem_req", 32'(mem_req), 32'd0);
      tick();
      check_eq("rd new mem_addr", mem_addr, 32'h50);
      mem_ready = 1; mem_rdata = 32'h00500093;
      tick();
      mem_ready = 0;
      settle();
      check_eq("rd new if_valid", 32'(if_valid), 32'd1);
      check_eq("rd new if_rdata", if_rdata, 32'h00500093);
      if_req = 0;
      tick();

      // Back-to-back fetches with if_req held.
      if_req = 1; if_addr = 32'h0;
      tick();
      check_eq("bb f0 mem_addr", mem_addr, 32'h0);
      mem_ready = 1; mem_rdata = 32'h000000A0;
      tick();
      mem_ready = 0;
      settle();
      check_eq("bb f0 if_valid", 32'(if_valid), 32'd1);
      check_eq("bb f0 if_rdata", if_rdata, 32'h000000A0);
      if_addr = 32'h4;
      tick();
      check_eq("bb idle mem_req", 32'(mem_req), 32'd0);
      check_eq("bb idle if_valid", 32'(if_valid), 32'd0);
      tick();
      check_eq("bb f1 mem_addr", mem_addr, 32'h4);
      mem_ready = 1; mem_rdata = 32'h000000A4;
      tick();
      mem_ready = 0;
      settle();
      check_eq("bb f1 if_valid", 32'(if_valid), 32'd1);
      check_eq("bb f1 if_rdata", if_rdata, 32'h000000A4);
      if_req = 0;
      tick();
      check_eq("bb end mem_req", 32'(mem_req), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
